// File: rtl/mul_pkg.sv
// Shared constants and types for the multiplier result path.
package mul_pkg;

  // Operand width of the upstream multiplier; products are twice as wide.
  localparam int W = 32;

  // Cycles from issue to result at the multiplier output.
  localparam int MUL_LAT = 4;

  // Default number of result buffer entries (power of two, >= 2).
  localparam int RESBUF_DEPTH = 8;

  typedef logic [2*W-1:0] prod_t;

endpackage : mul_pkg

// File: rtl/mul_resbuf_ram.sv
// Result storage: DEPTH x DW array, one write port and one registered
// read port. The read register is write-first, so an entry written to the
// address being read appears in the read register on the same edge.
module mul_resbuf_ram
  import mul_pkg::*;
#(
  parameter int  DW    = $bits(prod_t),
  parameter int  DEPTH = RESBUF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port.
  // NOTE: the storage array has no reset; only control state and the read
  // register need a known value, and leaving the array unreset lets it map
  // onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, forwarding a same-cycle write to the read address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (we_i && (waddr_i == raddr_i)) begin
      rdata_q <= wdata_i;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule : mul_resbuf_ram

// File: rtl/mul_result_buf.sv
// In-order result buffer behind a fixed-latency multiplier. Issue is
// throttled by a reservation counter so that every issued product has a
// slot waiting for it; results are delivered FIFO to a ready/valid consumer.
// Optional feature: define MUL_RESBUF_HWM_EN to build the occupancy
// high-watermark register; otherwise hwm is tied to zero.
module mul_result_buf #(
  parameter int W     = mul_pkg::W,
  parameter int DEPTH = mul_pkg::RESBUF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue,
  output logic                     can_issue,
  input  logic                     res_valid,
  input  logic [2*W-1:0]           res_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   hwm
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] resv_q, resv_d;
  logic          err_q, err_d;

  logic [CW-1:0] cnt;
  logic          full;
  logic          pop;
  logic          push_acc;

  assign cnt       = wr_ptr_q - rd_ptr_q;
  assign full      = (cnt == DEPTH_C);
  assign out_valid = (cnt != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer still accepts a result when the head leaves this cycle.
  assign push_acc  = res_valid && (!full || pop);
  // Decoded from registered state only; issue and out_ready do not reach it.
  assign can_issue = (resv_q < DEPTH_C);

  // Next-state for pointers, reservations and the sticky error flag.
  // NOTE: every output of this block gets its hold value first, so no path
  // through it leaves a variable unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    resv_d   = resv_q;
    err_d    = err_q;

    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + CW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
    end

    // Issue and pop together leave the reservation count unchanged. Both
    // directions saturate: an issue past DEPTH is a protocol error, and a pop
    // with no reservation happens for results that arrived after a reset.
    unique case ({issue, pop})
      2'b10: if (resv_q != DEPTH_C) resv_d = resv_q + CW'(1);
      2'b01: if (resv_q != '0)      resv_d = resv_q - CW'(1);
      default: ;
    endcase

    if ((res_valid && full && !pop) || (issue && !can_issue)) begin
      err_d = 1'b1;
    end
  end

  // Control state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      resv_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      resv_q   <= resv_d;
      err_q    <= err_d;
    end
  end

  assign count = cnt;
  assign err   = err_q;

  // The read port always fetches the entry that will be head after this edge,
  // which gives one-cycle push-to-head latency without a combinational bypass.
  mul_resbuf_ram #(
    .DW    (2*W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (res_data),
    .raddr_i (rd_ptr_d[AW-1:0]),
    .rdata_o (out_data)
  );

`ifdef MUL_RESBUF_HWM_EN
  logic [CW-1:0] hwm_q;

  // Track the highest occupancy seen since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (cnt > hwm_q) begin
      hwm_q <= cnt;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

endmodule : mul_result_buf

// File: tb/tb_mul_result_buf.sv
// Self-checking bench for mul_result_buf: a 4-cycle multiplier model feeds
// the buffer, expected products go into a scoreboard queue at issue time and
// are compared when the consumer pops them.
module tb_mul_result_buf;
  import mul_pkg::*;

  localparam int DEPTH = RESBUF_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue = 1'b0;
  logic          res_valid = 1'b0;
  logic          out_ready = 1'b0;
  prod_t         res_data = '0;
  logic          can_issue;
  logic          out_valid;
  logic          err;
  prod_t         out_data;
  logic [CW-1:0] count;
  logic [CW-1:0] hwm;

  int    checks = 0;
  int    errors = 0;
  prod_t sb[$];
  bit    pipe_v[MUL_LAT];
  prod_t pipe_d[MUL_LAT];
  bit    mul_en = 1'b1;

  always #5 clk = ~clk;

  mul_result_buf #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .can_issue (can_issue),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .err       (err),
    .hwm       (hwm)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit pipe_busy();
    bit b = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) b |= pipe_v[i];
    return b;
  endfunction

  // One clock cycle, entered and left at the falling edge. iss feeds both the
  // DUT and (if mul_en) the multiplier model; dv/dd inject a result directly,
  // dacc says whether the bench expects that injected result to be stored.
  task automatic tick(input bit iss, input bit rdy, input bit dv,
                      input prod_t dd, input bit dacc);
    logic [W-1:0] a, b;
    prod_t p, exp;
    a = W'($urandom);
    b = W'($urandom);
    p = prod_t'(a) * prod_t'(b);
    issue     = iss;
    out_ready = rdy;
    res_valid = pipe_v[MUL_LAT-1] | dv;
    res_data  = dv ? dd : pipe_d[MUL_LAT-1];
    if (iss && mul_en) sb.push_back(p);
    if (dv && dacc) sb.push_back(dd);
    #1;
    if (out_valid && rdy) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h with empty scoreboard", out_data);
      end else begin
        exp = sb.pop_front();
        if (out_data !== exp) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", out_data, exp);
        end
      end
    end
    @(posedge clk);
    for (int i = MUL_LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_d[i] = pipe_d[i-1];
    end
    pipe_v[0] = iss && mul_en;
    pipe_d[0] = p;
    @(negedge clk);
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < MUL_LAT; i++) begin
      pipe_v[i] = 1'b0;
      pipe_d[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    issue     = 1'b0;
    res_valid = 1'b0;
    out_ready = 1'b0;
    res_data  = '0;
    mul_en    = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pop until the scoreboard and multiplier model are empty, bounded.
  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (sb.size() != 0 || pipe_busy()); i++)
      tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: got %0d entries left expected 0", tag, sb.size());
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL %s_drain_count: got %0d expected 0", tag, count);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({count, out_valid, can_issue, err} !== {CW'(0), 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_flags: got count=%0d ov=%b ci=%b err=%b expected 0 0 1 0",
               count, out_valid, can_issue, err);
    end
    checks++;
    if (out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", out_data);
    end
    checks++;
    if (hwm !== '0) begin
      errors++;
      $display("FAIL reset_hwm: got %0d expected 0", hwm);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        checks++;
        if (can_issue !== 1'b1) begin
          errors++;
          $display("FAIL b2b_can_issue_before_last: got %b expected 1", can_issue);
        end
      end
      tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    end
    checks++;
    if (can_issue !== 1'b0) begin
      errors++;
      $display("FAIL b2b_can_issue_after_last: got %b expected 0", can_issue);
    end
    repeat (MUL_LAT) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected %0d", count, DEPTH);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_err: got %b expected 0", err);
    end
    drain("b2b");
    checks++;
    if (can_issue !== 1'b1) begin
      errors++;
      $display("FAIL b2b_can_issue_drained: got %b expected 1", can_issue);
    end
  endtask

  task automatic test_single_push();
    prod_t v;
    v = 64'h0000_0003_0000_0002;
    // Push into an empty buffer with the consumer ready: no bypass allowed.
    tick(1'b0, 1'b1, 1'b1, v, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== v) begin
      errors++;
      $display("FAIL single_head: got ov=%b data=%h expected ov=1 data=%h", out_valid, out_data, v);
    end
    checks++;
    if (sb.size() != 1) begin
      errors++;
      $display("FAIL single_no_bypass: got %0d queued expected 1", sb.size());
    end
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (count !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_popped: got count=%0d ov=%b expected 0 0", count, out_valid);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++)
      tick(1'b0, 1'b0, 1'b1, prod_t'(64'h1000 + i), 1'b1);
    checks++;
    if (count !== CW'(DEPTH)) begin
      errors++;
      $display("FAIL full_count: got %0d expected %0d", count, DEPTH);
    end
    // Push and pop together on a full buffer: push accepted.
    tick(1'b0, 1'b1, 1'b1, 64'hAAAA_0000_5555, 1'b1);
    checks++;
    if (count !== CW'(DEPTH) || err !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d err=%b expected %0d 0", count, err, DEPTH);
    end
    // Push without pop on a full buffer: dropped, error raised.
    tick(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    checks++;
    if (count !== CW'(DEPTH) || err !== 1'b1) begin
      errors++;
      $display("FAIL full_drop: got count=%0d err=%b expected %0d 1", count, err, DEPTH);
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got %b expected 1", err);
    end
    drain("full");
    do_reset();
  endtask

  task automatic test_issue_overflow();
    mul_en = 1'b0;
    repeat (DEPTH) tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (can_issue !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL ovf_at_depth: got ci=%b err=%b expected 0 0", can_issue, err);
    end
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (can_issue !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL ovf_issue: got ci=%b err=%b expected 0 1", can_issue, err);
    end
    // One pop must bring the saturated count from DEPTH to DEPTH-1.
    tick(1'b0, 1'b0, 1'b1, 64'h77, 1'b1);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    checks++;
    if (can_issue !== 1'b1) begin
      errors++;
      $display("FAIL ovf_saturated: got ci=%b expected 1", can_issue);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit iss;
    for (int c = 0; c < 1000; c++) begin
      iss = can_issue && ($urandom_range(0, 9) < 7);
      tick(iss, ($urandom_range(0, 1) == 1), 1'b0, '0, 1'b0);
    end
    drain("rand");
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rand_err: got %b expected 0", err);
    end
  endtask

  task automatic test_reset_mid();
    int peak_pre, peak_post;
`ifdef MUL_RESBUF_HWM_EN
    peak_pre  = 5;
    peak_post = 3;
`else
    peak_pre  = 0;
    peak_post = 0;
`endif
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, prod_t'(64'h500 + i), 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (count !== CW'(5) || hwm !== CW'(peak_pre)) begin
      errors++;
      $display("FAIL mid_before: got count=%0d hwm=%0d expected 5 %0d", count, hwm, peak_pre);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || can_issue !== 1'b1 || hwm !== '0) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d ov=%b ci=%b hwm=%0d expected 0 0 1 0",
               count, out_valid, can_issue, hwm);
    end
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, prod_t'(64'h900 + i), 1'b1);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (count !== CW'(3) || hwm !== CW'(peak_post)) begin
      errors++;
      $display("FAIL mid_refill: got count=%0d hwm=%0d expected 3 %0d", count, hwm, peak_post);
    end
    drain("mid");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_back_to_back();
    test_single_push();
    test_full();
    test_issue_overflow();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mul_result_buf
